axi_burst_memory_responder: RTL and testbench

AXI4 slave (responder) that terminates write and read bursts from an AXI4 initiator into an internal byte-addressed memory array. It supports FIXED, INCR and WRAP bursts, per-beat write strobes, and independent write and read paths. Error responses are returned for out-of-range or illegal requests. It is a synthesizable target for the AXI4 stimulus and monitoring infrastructure, and models DECERR/SLVERR behaviour that the simple RAM does not.

---
 rtl/axi_burst_memory_responder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axi_burst_memory_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_memory_responder.sv
// rtl/axi_burst_memory_responder.sv - AXI4 burst responder terminating reads/writes into a byte-addressed memory
// Optional feature macro: AXI_WRAP_BURST_EN (WRAP bursts supported; otherwise WRAP is reserved and returns SLVERR)
module axi_burst_memory_responder #(
  parameter int MEMORY_SIZE_BYTES = 4096,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 8,
  parameter int AXI_ADDR_WIDTH    = 32,
  parameter int AXI_STRB_WIDTH    = AXI_DATA_WIDTH / 8
) (
  input  logic                      axi_clk,
  input  logic                      axi_resetn,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
  input  logic [1:0]                axi_aw_burst,
  input  logic [2:0]                axi_aw_size,
  input  logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
  input  logic [7:0]                axi_aw_len,
  input  logic                      axi_aw_valid,
  output logic                      axi_aw_ready,
  input  logic [AXI_DATA_WIDTH-1:0] axi_w_data,
  input  logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
  input  logic                      axi_w_last,
  input  logic                      axi_w_valid,
  output logic                      axi_w_ready,
  output logic [1:0]                axi_b_resp,
  output logic [AXI_ID_WIDTH-1:0]   axi_b_id,
  output logic                      axi_b_valid,
  input  logic                      axi_b_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
  input  logic [1:0]                axi_ar_burst,
  input  logic [2:0]                axi_ar_size,
  input  logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
  input  logic [7:0]                axi_ar_len,
  input  logic                      axi_ar_valid,
  output logic                      axi_ar_ready,
  output logic [AXI_DATA_WIDTH-1:0] axi_r_data,
  output logic [AXI_ID_WIDTH-1:0]   axi_r_id,
  output logic [1:0]                axi_r_resp,
  output logic                      axi_r_last,
  output logic                      axi_r_valid,
  input  logic                      axi_r_ready
);

  typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;

  localparam int MAW       = $clog2(MEMORY_SIZE_BYTES);
  localparam int LANE_BITS = $clog2(AXI_STRB_WIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam addr_t      MEM_LIMIT   = addr_t'(MEMORY_SIZE_BYTES);
  localparam logic [MAW-1:0] LANE_MASK = MAW'(AXI_STRB_WIDTH - 1);
`ifdef AXI_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic [7:0] mem [MEMORY_SIZE_BYTES];

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic [1:0] burst_resp(input logic [2:0] size, input logic [1:0] burst,
                                            input logic [7:0] len);
    logic err;
    err = (int'(size) > LANE_BITS) || (burst == 2'b11);
    if (burst == BURST_WRAP && !(WRAP_EN && wrap_len_ok(len))) err = 1'b1;
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

  function automatic logic [1:0] beat_resp(input addr_t addr, input logic [1:0] brst);
    return (addr >= MEM_LIMIT) ? RESP_DECERR : brst;
  endfunction

  function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Reserved burst type and illegal-length WRAP both advance like INCR.
  function automatic addr_t next_addr(input addr_t addr, input logic [2:0] size,
                                      input logic [1:0] burst, input logic [7:0] len);
    addr_t bytes, aligned, incr, container, lower;
    bytes     = addr_t'(1) << size;
    aligned   = addr & ~(bytes - addr_t'(1));
    incr      = aligned + bytes;
    container = (addr_t'(len) + addr_t'(1)) << size;
    lower     = addr & ~(container - addr_t'(1));
    if (burst == BURST_FIXED) return addr;
    if (WRAP_EN && burst == BURST_WRAP && wrap_len_ok(len) && incr == lower + container)
      return lower;
    return incr;
  endfunction

  function automatic logic [AXI_DATA_WIDTH-1:0] rd_word(input addr_t addr);
    logic [AXI_DATA_WIDTH-1:0] d;
    logic [MAW-1:0]            base;
    d    = '0;
    base = MAW'(addr) & ~LANE_MASK;
    if (addr < MEM_LIMIT)
      for (int i = 0; i < AXI_STRB_WIDTH; i++) d[8*i +: 8] = mem[base + MAW'(i)];
    return d;
  endfunction

  // ---------------- write path ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t                w_state;
  addr_t                   wr_addr;
  logic [1:0]              wr_burst;
  logic [2:0]              wr_size;
  logic [7:0]              wr_len;
  logic [7:0]              wr_beat;
  logic [AXI_ID_WIDTH-1:0] wr_id;
  logic [1:0]              wr_err;
  logic                    w_fire;
  logic                    wr_en;
  logic [1:0]              w_beat_resp;
  logic [1:0]              w_acc;
  logic [MAW-1:0]          wr_base;

  assign w_fire  = axi_w_valid && axi_w_ready;
  assign wr_en   = w_fire && (wr_addr < MEM_LIMIT);
  assign wr_base = MAW'(wr_addr) & ~LANE_MASK;

  always_comb begin
    w_beat_resp = beat_resp(wr_addr, burst_resp(wr_size, wr_burst, wr_len));
    if (axi_w_last ? (wr_beat != wr_len) : (wr_beat >= wr_len))
      w_beat_resp = worse(w_beat_resp, RESP_SLVERR);
    w_acc = worse(wr_err, w_beat_resp);
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      w_state      <= W_IDLE;
      axi_aw_ready <= 1'b0;
      axi_w_ready  <= 1'b0;
      axi_b_valid  <= 1'b0;
      axi_b_resp   <= RESP_OKAY;
      axi_b_id     <= '0;
      wr_addr      <= '0;
      wr_burst     <= '0;
      wr_size      <= '0;
      wr_len       <= '0;
      wr_beat      <= '0;
      wr_id        <= '0;
      wr_err       <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          axi_aw_ready <= 1'b1;
          if (axi_aw_valid && axi_aw_ready) begin
            axi_aw_ready <= 1'b0;
            axi_w_ready  <= 1'b1;
            wr_addr      <= axi_aw_addr;
            wr_burst     <= axi_aw_burst;
            wr_size      <= axi_aw_size;
            wr_len       <= axi_aw_len;
            wr_id        <= axi_aw_id;
            wr_beat      <= 8'd0;
            wr_err       <= RESP_OKAY;
            w_state      <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (axi_w_last) begin
              axi_w_ready <= 1'b0;
              axi_b_valid <= 1'b1;
              axi_b_resp  <= w_acc;
              axi_b_id    <= wr_id;
              w_state     <= W_RESP;
            end else begin
              wr_err <= w_acc;
              // Beats past len keep landing on the last computed address.
              if (wr_beat < wr_len) begin
                wr_addr <= next_addr(wr_addr, wr_size, wr_burst, wr_len);
                wr_beat <= wr_beat + 8'd1;
              end
            end
          end
        end
        W_RESP: begin
          if (axi_b_valid && axi_b_ready) begin
            axi_b_valid  <= 1'b0;
            axi_aw_ready <= 1'b1;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge axi_clk) begin
    if (wr_en)
      for (int i = 0; i < AXI_STRB_WIDTH; i++)
        if (axi_w_strb[i]) mem[wr_base + MAW'(i)] <= axi_w_data[8*i +: 8];
  end

  // ---------------- read path ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t   r_state;
  addr_t      rd_addr;
  logic [1:0] rd_burst;
  logic [2:0] rd_size;
  logic [7:0] rd_len;
  logic [7:0] rd_beat;

  // Reads sample mem on the same edge as writes, so a colliding read sees old data.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state      <= R_IDLE;
      axi_ar_ready <= 1'b0;
      axi_r_valid  <= 1'b0;
      axi_r_data   <= '0;
      axi_r_id     <= '0;
      axi_r_resp   <= RESP_OKAY;
      axi_r_last   <= 1'b0;
      rd_addr      <= '0;
      rd_burst     <= '0;
      rd_size      <= '0;
      rd_len       <= '0;
      rd_beat      <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          axi_ar_ready <= 1'b1;
          if (axi_ar_valid && axi_ar_ready) begin
            axi_ar_ready <= 1'b0;
            rd_burst     <= axi_ar_burst;
            rd_size      <= axi_ar_size;
            rd_len       <= axi_ar_len;
            rd_addr      <= next_addr(axi_ar_addr, axi_ar_size, axi_ar_burst, axi_ar_len);
            rd_beat      <= 8'd1;
            axi_r_id     <= axi_ar_id;
            axi_r_data   <= rd_word(axi_ar_addr);
            axi_r_resp   <= beat_resp(axi_ar_addr, burst_resp(axi_ar_size, axi_ar_burst, axi_ar_len));
            axi_r_last   <= (axi_ar_len == 8'd0);
            axi_r_valid  <= 1'b1;
            r_state      <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi_r_valid && axi_r_ready && axi_r_last) begin
            axi_r_valid  <= 1'b0;
            axi_r_last   <= 1'b0;
            axi_ar_ready <= 1'b1;
            r_state      <= R_IDLE;
          end else if (!axi_r_valid || axi_r_ready) begin
            axi_r_data  <= rd_word(rd_addr);
            axi_r_resp  <= beat_resp(rd_addr, burst_resp(rd_size, rd_burst, rd_len));
            axi_r_last  <= (rd_beat == rd_len);
            axi_r_valid <= 1'b1;
            rd_addr     <= next_addr(rd_addr, rd_size, rd_burst, rd_len);
            rd_beat     <= rd_beat + 8'd1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_memory_responder.sv
// tb/tb_axi_burst_memory_responder.sv - scoreboard bench for axi_burst_memory_responder
// Build with AXI_WRAP_BURST_EN defined or not; WRAP expectations follow the macro.
module tb_axi_burst_memory_responder;
  localparam int MEM = 4096;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] aw_addr, ar_addr, w_data, r_data;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [2:0]  aw_size, ar_size;
  logic [7:0]  aw_id, ar_id, aw_len, ar_len, b_id, r_id;
  logic [3:0]  w_strb;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready;

  always #5 clk = ~clk;

  axi_burst_memory_responder dut (
    .axi_clk(clk), .axi_resetn(rst_n),
    .axi_aw_addr(aw_addr), .axi_aw_burst(aw_burst), .axi_aw_size(aw_size), .axi_aw_id(aw_id),
    .axi_aw_len(aw_len), .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready),
    .axi_w_data(w_data), .axi_w_strb(w_strb), .axi_w_last(w_last), .axi_w_valid(w_valid),
    .axi_w_ready(w_ready), .axi_b_resp(b_resp), .axi_b_id(b_id), .axi_b_valid(b_valid),
    .axi_b_ready(b_ready), .axi_ar_addr(ar_addr), .axi_ar_burst(ar_burst), .axi_ar_size(ar_size),
    .axi_ar_id(ar_id), .axi_ar_len(ar_len), .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready),
    .axi_r_data(r_data), .axi_r_id(r_id), .axi_r_resp(r_resp), .axi_r_last(r_last),
    .axi_r_valid(r_valid), .axi_r_ready(r_ready)
  );

  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last; logic [7:0] id;} rbeat_t;
  typedef struct packed {logic [1:0] resp; logic [7:0] id;} bexp_t;
  rbeat_t      exp_r[$];
  bexp_t       exp_b[$];
  logic [31:0] wdata [16];
  logic [3:0]  wstrb [16];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_r(input logic [31:0] d, input logic [1:0] rsp, input logic lst, input logic [7:0] tid);
    exp_r.push_back('{data: d, resp: rsp, last: lst, id: tid});
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [7:0] tid, input int nbeats,
                          input logic [1:0] exp_resp);
    bexp_t e;
    exp_b.push_back('{resp: exp_resp, id: tid});
    aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_id = tid; aw_valid = 1'b1;
    for (int t = 0; t < 50 && !aw_ready; t++) @(negedge clk);
    chk("aw_ready", aw_ready, 1);
    @(negedge clk);
    aw_valid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      w_data = wdata[b]; w_strb = wstrb[b]; w_last = (b == nbeats - 1); w_valid = 1'b1;
      for (int t = 0; t < 50 && !w_ready; t++) @(negedge clk);
      chk("w_ready", w_ready, 1);
      @(negedge clk);
    end
    w_valid = 1'b0; w_last = 1'b0;
    b_ready = 1'b1;
    for (int t = 0; t < 50 && !b_valid; t++) @(negedge clk);
    chk("b_valid", b_valid, 1);
    e = exp_b.pop_front();
    chk("b_resp", b_resp, e.resp);
    chk("b_id", b_id, e.id);
    @(negedge clk);
    b_ready = 1'b0;
    chk("b_valid_drop", b_valid, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [7:0] tid, input logic [3:0] pat);
    rbeat_t h;
    ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = tid; ar_valid = 1'b1;
    for (int t = 0; t < 50 && !ar_ready; t++) @(negedge clk);
    chk("ar_ready", ar_ready, 1);
    chk("r_valid_before", r_valid, 0);
    @(negedge clk);
    ar_valid = 1'b0;
    chk("r_first_valid", r_valid, 1);
    for (int cyc = 0; cyc < 300 && exp_r.size() > 0; cyc++) begin
      r_ready = pat[cyc % 4];
      if (r_valid) begin
        h = exp_r[0];
        chk("r_data", r_data, h.data);
        chk("r_resp", r_resp, h.resp);
        chk("r_last", r_last, h.last);
        chk("r_id", r_id, h.id);
        if (r_ready) void'(exp_r.pop_front());
      end
      @(negedge clk);
    end
    r_ready = 1'b0;
    chk("r_beats_left", exp_r.size(), 0);
    chk("r_valid_idle", r_valid, 0);
    chk("ar_ready_back", ar_ready, 1);
    exp_r.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    aw_addr = '0; aw_burst = '0; aw_size = '0; aw_id = '0; aw_len = '0; aw_valid = 1'b0;
    ar_addr = '0; ar_burst = '0; ar_size = '0; ar_id = '0; ar_len = '0; ar_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin wdata[i] = '0; wstrb[i] = 4'hF; end
    repeat (3) @(negedge clk);
    chk("rst_aw_ready", aw_ready, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_ar_ready", ar_ready, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_data", r_data, 0);
    rst_n = 1'b1;
    #1 chk("rel_aw_ready_low", aw_ready, 0);
    @(negedge clk);
    chk("rel_aw_ready", aw_ready, 1);
    chk("rel_ar_ready", ar_ready, 1);

    // INCR write/read at 0x10
    wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33; wdata[3] = 32'h44;
    do_write(32'h10, 8'd3, 3'd2, 2'b01, 8'h5A, 4, OKAY);
    push_r(32'h11, OKAY, 0, 8'h3C); push_r(32'h22, OKAY, 0, 8'h3C);
    push_r(32'h33, OKAY, 0, 8'h3C); push_r(32'h44, OKAY, 1, 8'h3C);
    do_read(32'h10, 8'd3, 3'd2, 2'b01, 8'h3C, 4'b1111);

    // reserved burst type advances as INCR with SLVERR
    push_r(32'h11, SLVERR, 0, 8'h21); push_r(32'h22, SLVERR, 1, 8'h21);
    do_read(32'h10, 8'd1, 3'd2, 2'b11, 8'h21, 4'b1111);

    // byte strobes
    wdata[0] = 32'hAABBCCDD;
    do_write(32'h0, 8'd0, 3'd2, 2'b01, 8'h01, 1, OKAY);
    wdata[0] = 32'h11223344; wstrb[0] = 4'h5;
    do_write(32'h0, 8'd0, 3'd2, 2'b01, 8'h02, 1, OKAY);
    wstrb[0] = 4'hF;
    push_r(32'hAA22CC44, OKAY, 1, 8'h03);
    do_read(32'h0, 8'd0, 3'd2, 2'b01, 8'h03, 4'b1111);

    // len 7 read with r_ready stalls 1,0,0,1
    for (int i = 0; i < 8; i++) wdata[i] = 32'hC0DE0000 | i;
    do_write(32'h30, 8'd7, 3'd2, 2'b01, 8'h07, 8, OKAY);
    for (int i = 0; i < 8; i++) push_r(32'hC0DE0000 | i, OKAY, i == 7, 8'h08);
    do_read(32'h30, 8'd7, 3'd2, 2'b01, 8'h08, 4'b1001);

    // WRAP read at 0x38 len 3
`ifdef AXI_WRAP_BURST_EN
    push_r(32'hC0DE0002, OKAY, 0, 8'h09); push_r(32'hC0DE0003, OKAY, 0, 8'h09);
    push_r(32'hC0DE0000, OKAY, 0, 8'h09); push_r(32'hC0DE0001, OKAY, 1, 8'h09);
`else
    push_r(32'hC0DE0002, SLVERR, 0, 8'h09); push_r(32'hC0DE0003, SLVERR, 0, 8'h09);
    push_r(32'hC0DE0004, SLVERR, 0, 8'h09); push_r(32'hC0DE0005, SLVERR, 1, 8'h09);
`endif
    do_read(32'h38, 8'd3, 3'd2, 2'b10, 8'h09, 4'b1111);

    // out-of-range: DECERR, in-range beat still written, nothing aliased into low memory
    wdata[0] = 32'hDEADBEEF; wdata[1] = 32'h01020304;
    do_write(MEM - 4, 8'd1, 3'd2, 2'b01, 8'h66, 2, DECERR);
    push_r(32'hDEADBEEF, OKAY, 1, 8'h0A);
    do_read(MEM - 4, 8'd0, 3'd2, 2'b01, 8'h0A, 4'b1111);
    push_r(32'h0, DECERR, 1, 8'h0B);
    do_read(MEM, 8'd0, 3'd2, 2'b01, 8'h0B, 4'b1111);
    push_r(32'hAA22CC44, OKAY, 1, 8'h0C);
    do_read(32'h0, 8'd0, 3'd2, 2'b01, 8'h0C, 4'b1111);

    // early w_last: SLVERR but data still written
    wdata[0] = 32'h12345678;
    do_write(32'h200, 8'd1, 3'd2, 2'b01, 8'h77, 1, SLVERR);
    push_r(32'h12345678, OKAY, 1, 8'h0D);
    do_read(32'h200, 8'd0, 3'd2, 2'b01, 8'h0D, 4'b1111);

    // reset during beat 2 of a len 7 write
    aw_addr = 32'h100; aw_len = 8'd7; aw_size = 3'd2; aw_burst = 2'b01; aw_id = 8'h99; aw_valid = 1'b1;
    for (int t = 0; t < 50 && !aw_ready; t++) @(negedge clk);
    chk("mid_aw_ready", aw_ready, 1);
    @(negedge clk);
    aw_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      w_data = b; w_strb = 4'hF; w_valid = 1'b1;
      for (int t = 0; t < 50 && !w_ready; t++) @(negedge clk);
      chk("mid_w_ready", w_ready, 1);
      @(negedge clk);
    end
    w_data = 32'h2; w_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_w_ready", w_ready, 0);
    chk("mid_rst_b_valid", b_valid, 0);
    w_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_rel_aw_low", aw_ready, 0);
    @(negedge clk);
    chk("mid_rel_aw_ready", aw_ready, 1);
    chk("mid_rel_b_valid", b_valid, 0);
    wdata[0] = 32'h5555AAAA;
    do_write(32'h100, 8'd0, 3'd2, 2'b01, 8'h42, 1, OKAY);
    push_r(32'h5555AAAA, OKAY, 1, 8'h0E);
    do_read(32'h100, 8'd0, 3'd2, 2'b01, 8'h0E, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
